// File: rtl/frame_deserializer.sv
// frame_deserializer: hunts HEADER, buffers NUM_CHANNELS bytes in a ping-pong bank, checks FOOTER, replays good frames.
// Optional FRAME_STATS_EN adds saturating good/aborted frame counters on ok_cnt/err_cnt.
module frame_deserializer #(
  parameter logic [7:0] HEADER = 8'hAA,
  parameter logic [7:0] FOOTER = 8'hFF,
  parameter int NUM_CHANNELS = 16,
  parameter int TIMEOUT = 64,
  localparam int CW = $clog2(NUM_CHANNELS),
  localparam int IW = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    din,
  input  logic          din_valid,
  output logic [7:0]    dout,
  output logic [CW-1:0] dout_ch,
  output logic          dout_valid,
  output logic          frame_ok,
  output logic          frame_err,
  output logic [15:0]   ok_cnt,
  output logic [15:0]   err_cnt
);
  typedef enum logic [1:0] {HUNT, DATA, TAIL} state_t;
  state_t state, state_n;
  logic [CW-1:0] wr_idx, wr_idx_n, rd_idx;
  logic [IW-1:0] idle, idle_n;
  logic wr_bank, rd_bank, rd_act, start, abort, rd_last;
  logic [7:0] mem [2][NUM_CHANNELS];
  assign rd_last = rd_idx == CW'(NUM_CHANNELS - 1);
  always_comb begin
    state_n = state;
    wr_idx_n = wr_idx;
    idle_n = '0;
    start = 1'b0;
    abort = 1'b0;
    case (state)
      HUNT: if (din_valid && din == HEADER) begin
        state_n = DATA;
        wr_idx_n = '0;
      end
      DATA: if (din_valid) begin
        wr_idx_n = wr_idx + 1'b1;
        state_n = wr_idx == CW'(NUM_CHANNELS - 1) ? TAIL : DATA;
      end
      TAIL: if (din_valid) begin
        state_n = HUNT;
        start = din == FOOTER;
        abort = din != FOOTER;
      end
      default: state_n = HUNT;
    endcase
    // idle cycles only matter once a frame is open
    if (state != HUNT && !din_valid) begin
      idle_n = idle + 1'b1;
      if (idle == IW'(TIMEOUT - 1)) begin
        state_n = HUNT;
        abort = 1'b1;
        idle_n = '0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HUNT;
      wr_idx <= '0;
      idle <= '0;
      wr_bank <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state <= state_n;
      wr_idx <= wr_idx_n;
      idle <= idle_n;
      wr_bank <= wr_bank ^ start;
      frame_err <= abort;
    end
  end
  always_ff @(posedge clk) begin
    if (state == DATA && din_valid) mem[wr_bank][wr_idx] <= din;
  end
  // the fill bank is handed over on footer; the first byte goes out the very next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
      dout_ch <= '0;
      dout_valid <= 1'b0;
      frame_ok <= 1'b0;
      rd_bank <= 1'b0;
      rd_idx <= '0;
      rd_act <= 1'b0;
    end else if (start) begin
      dout <= mem[wr_bank][0];
      dout_ch <= '0;
      dout_valid <= 1'b1;
      frame_ok <= 1'b0;
      rd_bank <= wr_bank;
      rd_idx <= CW'(1);
      rd_act <= 1'b1;
    end else if (rd_act) begin
      dout <= mem[rd_bank][rd_idx];
      dout_ch <= rd_idx;
      dout_valid <= 1'b1;
      frame_ok <= rd_last;
      rd_idx <= rd_idx + 1'b1;
      rd_act <= !rd_last;
    end else begin
      dout_valid <= 1'b0;
      frame_ok <= 1'b0;
    end
  end
`ifdef FRAME_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ok_cnt <= '0;
      err_cnt <= '0;
    end else begin
      ok_cnt <= ok_cnt + 16'(frame_ok && ok_cnt != 16'hFFFF);
      err_cnt <= err_cnt + 16'(frame_err && err_cnt != 16'hFFFF);
    end
  end
`else
  assign ok_cnt = '0;
  assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_frame_deserializer.sv
// tb_frame_deserializer: directed frames; expected replay bytes queued at footer time, checked by a monitor.
module tb_frame_deserializer;
  logic clk = 1'b0, rst_n = 1'b0, din_valid = 1'b0, frame_ok, frame_err, dout_valid;
  logic [7:0] din = '0, dout;
  logic [3:0] dout_ch;
  logic [15:0] ok_cnt, err_cnt;
  typedef struct packed {logic [7:0] d; logic [3:0] ch; logic ok;} exp_t;
  exp_t q[$];
  exp_t e;
  logic [7:0] pay [16];
  int vectors = 0, miscompares = 0, ok_seen = 0, err_seen = 0, exp_ok = 0, exp_err = 0, s_ok = 0, s_err = 0;
  logic hit;
  frame_deserializer dut (.clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .dout(dout),
    .dout_ch(dout_ch), .dout_valid(dout_valid), .frame_ok(frame_ok), .frame_err(frame_err),
    .ok_cnt(ok_cnt), .err_cnt(err_cnt));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) if (rst_n) begin
    if (frame_err) err_seen++;
    if (frame_ok) ok_seen++;
    if (dout_valid) begin
      if (q.size() == 0) chk("unexpected_dout", {dout_ch, dout}, 32'hFFFF_FFFF);
      else begin
        e = q.pop_front();
        chk("dout", dout, e.d);
        chk("dout_ch", dout_ch, e.ch);
        chk("frame_ok", frame_ok, e.ok);
      end
    end
  end
  task automatic send(input logic [7:0] b);
    din = b;
    din_valid = 1'b1;
    @(posedge clk);
    #1 din_valid = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic frame();
    send(8'hAA);
    for (int i = 0; i < 16; i++) send(pay[i]);
    for (int i = 0; i < 16; i++) q.push_back(exp_t'{pay[i], 4'(i), i == 15});
    exp_ok++;
    s_ok++;
    send(8'hFF);
  endtask
  task automatic check_stats();
`ifdef FRAME_STATS_EN
    chk("ok_cnt", ok_cnt, s_ok);
    chk("err_cnt", err_cnt, s_err);
`endif
    chk("queue_drained", q.size(), 0);
    chk("ok_pulses", ok_seen, exp_ok);
    chk("err_pulses", err_seen, exp_err);
  endtask
  initial begin
    #1000000 $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_dout_ch", dout_ch, 0);
    chk("rst_frame_ok", frame_ok, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_ok_cnt", ok_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    rst_n = 1'b1;
    idle(2);
    for (int i = 0; i < 16; i++) pay[i] = 8'(i);
    frame();
    chk("t1_first_valid", dout_valid, 1);
    chk("t1_first_ch", dout_ch, 0);
    idle(15);
    chk("t1_ok_at_ch15", frame_ok, 1);
    idle(1);
    chk("t1_valid_drops", dout_valid, 0);
    idle(5);
    check_stats();
    for (int i = 0; i < 16; i++) pay[i] = 8'h10 + 8'(i);
    frame();
    idle(1);
    for (int i = 0; i < 16; i++) pay[i] = 8'h80 + 8'(i * 3);
    frame();
    idle(20);
    check_stats();
    send(8'hAA);
    for (int i = 0; i < 16; i++) send(8'h40 + 8'(i));
    send(8'h55);
    exp_err++;
    s_err++;
    chk("t3_err_pulse", frame_err, 1);
    idle(3);
    for (int i = 0; i < 16; i++) pay[i] = 8'hF0 - 8'(i);
    frame();
    idle(20);
    check_stats();
    send(8'h12);
    send(8'h34);
    send(8'hFF);
    for (int i = 0; i < 16; i++) pay[i] = 8'(i * 17);
    frame();
    idle(20);
    check_stats();
    send(8'hAA);
    for (int i = 0; i < 5; i++) send(8'h20 + 8'(i));
    idle(63);
    chk("t5_no_err_yet", frame_err, 0);
    idle(1);
    chk("t5_timeout_err", frame_err, 1);
    exp_err++;
    s_err++;
    idle(2);
    for (int i = 0; i < 16; i++) pay[i] = 8'h5A ^ 8'(i);
    frame();
    idle(20);
    check_stats();
    for (int i = 0; i < 16; i++) pay[i] = 8'hC0 + 8'(i);
    frame();
    hit = 1'b0;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(negedge clk);
      hit = dout_valid && dout_ch == 4'd7;
    end
    chk("t6_reach_ch7", hit, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", dout_valid, 0);
    chk("t6_async_dout", dout, 0);
    chk("t6_async_ch", dout_ch, 0);
    q.delete();
    exp_ok--;
    s_ok = 0;
    s_err = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    idle(20);
    check_stats();
    for (int i = 0; i < 16; i++) pay[i] = 8'h33 + 8'(i * 5);
    frame();
    idle(20);
    check_stats();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
